// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing recovery: rebuilds x/y/de from active-low hs/vs,
// measures line and frame totals, and qualifies the timing with a lock FSM.
module vga_timing_decoder #(
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 491,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs,
  input  logic       vs,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       locked,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       err
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] X_LOAD = 10'(H_SYNC_START + 1);
  localparam logic [9:0] Y_LOAD = 10'(V_SYNC_START);
  localparam logic [1:0] LOCK_N = 2'(LOCK_FRAMES);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t     state, state_n;
  logic       hs_d, vs_d;
  logic [9:0] hp, lc;
  logic [9:0] h_first, prev_h, prev_lc;
  logic       h_first_vld, h_bad, prev_vld;
  logic [1:0] mc, mc_n;
  logic       err_q, err_n;

  logic       hs_fall, vs_fall, line_adv;
  logic       hp_sat, lc_sat, h_bad_eff, frame_match;
  logic [9:0] period, lc_eff, h_first_eff, x_n, y_n;

  // A simultaneous hs fall is folded into the ending frame before vs acts on it.
  always_comb begin
    hs_fall     = hs_d & ~hs;
    vs_fall     = vs_d & ~vs;
    period      = hp + 10'd1;
    hp_sat      = !hs_fall && (hp == CNT_MAX - 10'd1);
    lc_sat      = hs_fall && (lc == CNT_MAX - 10'd1);
    lc_eff      = lc;
    h_first_eff = h_first;
    h_bad_eff   = h_bad;
    if (hs_fall) begin
      if (lc != CNT_MAX) lc_eff = lc + 10'd1;
      if (!h_first_vld) h_first_eff = period;
      else if (period != h_first) h_bad_eff = 1'b1;
    end
    frame_match = !h_bad_eff &&
                  (!prev_vld || (h_first_eff == prev_h && lc_eff == prev_lc));
  end

  always_comb begin
    x_n      = x;
    y_n      = y;
    line_adv = 1'b0;
    if (hs_fall) begin
      x_n = X_LOAD;
    end else if (h_total == 10'd0) begin
      x_n = (x == CNT_MAX) ? x : x + 10'd1;
    end else if (x == h_total - 10'd1) begin
      x_n      = 10'd0;
      line_adv = 1'b1;
    end else begin
      x_n = x + 10'd1;
    end
    if (vs_fall) y_n = Y_LOAD;
    else if (line_adv) y_n = (y == v_total - 10'd1) ? 10'd0 : y + 10'd1;
  end

  always_comb begin
    state_n = state;
    mc_n    = mc;
    err_n   = hp_sat || lc_sat;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_n = TRACK;
          mc_n    = 2'd0;
        end
      end
      TRACK: begin
        if (vs_fall) begin
          if (frame_match) begin
            mc_n = mc + 2'd1;
            if (mc + 2'd1 == LOCK_N) state_n = LOCKED;
          end else begin
            mc_n = 2'd0;
          end
        end
      end
      LOCKED: begin
        if ((hs_fall && period != h_total) || (vs_fall && lc_eff != v_total))
          err_n = 1'b1;
      end
      default: state_n = SEARCH;
    endcase
    if (err_n) begin
      state_n = SEARCH;
      mc_n    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEARCH;
      mc          <= 2'd0;
      err_q       <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      hp          <= 10'd0;
      lc          <= 10'd0;
      x           <= 10'd0;
      y           <= 10'd0;
      de          <= 1'b0;
      h_total     <= 10'd0;
      v_total     <= 10'd0;
      h_first     <= 10'd0;
      h_first_vld <= 1'b0;
      h_bad       <= 1'b0;
      prev_h      <= 10'd0;
      prev_lc     <= 10'd0;
      prev_vld    <= 1'b0;
    end else begin
      state <= state_n;
      mc    <= mc_n;
      err_q <= err_n;
      hs_d  <= hs;
      vs_d  <= vs;
      x     <= x_n;
      y     <= y_n;
      de    <= (state_n == LOCKED) && (x_n < H_ACT) && (y_n < V_ACT);
      if (hs_fall) begin
        hp      <= 10'd0;
        h_total <= period;
      end else if (hp != CNT_MAX) begin
        hp <= hp + 10'd1;
      end
      // The frame just closed becomes the reference only if it was fully tracked.
      if (vs_fall) begin
        lc          <= 10'd0;
        v_total     <= lc_eff;
        prev_h      <= h_first_eff;
        prev_lc     <= lc_eff;
        prev_vld    <= (state != SEARCH);
        h_first_vld <= 1'b0;
        h_bad       <= 1'b0;
      end else if (hs_fall) begin
        lc          <= lc_eff;
        h_first     <= h_first_eff;
        h_first_vld <= 1'b1;
        h_bad       <= h_bad_eff;
      end
    end
  end

  assign locked = (state == LOCKED);
  assign err    = err_q & ~rst;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder: a small sync generator feeds the decoder on a
// reduced 80x30 geometry so that many frames fit in a short run.
module tb_vga_timing_decoder;

  localparam int H_TOT    = 80;
  localparam int H_ACT    = 64;
  localparam int HS_START = 68;
  localparam int HS_W     = 8;
  localparam int V_TOT    = 30;
  localparam int V_ACT    = 24;
  localparam int VS_START = 26;
  localparam int VS_W     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs  = 1'b1;
  logic       vs  = 1'b1;
  logic [9:0] x, y, h_total, v_total;
  logic       de, locked, err;

  vga_timing_decoder #(
    .H_ACTIVE(H_ACT), .H_SYNC_START(HS_START), .V_ACTIVE(V_ACT),
    .V_SYNC_START(VS_START), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .x(x), .y(y), .de(de),
    .locked(locked), .h_total(h_total), .v_total(v_total), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gx;
    int gy;
    int ex;
    int ey;
    int ede;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   gx = 10, gy = 5;
  int   line_len = H_TOT, frame_len = V_TOT;
  bit   hs_hold = 0, vs_force = 0, hs_fell = 0, vs_fell = 0;
  int   err_hi = 0, de_hi = 0;

  always @(negedge clk) begin
    if (err) err_hi++;
    if (de) de_hi++;
  end

  task automatic driveSync();
    logic hs_new, vs_new;
    hs_new  = hs_hold || !(gx >= HS_START && gx < HS_START + HS_W);
    vs_new  = !vs_force && !(gy >= VS_START && gy < VS_START + VS_W);
    hs_fell = hs && !hs_new;
    vs_fell = vs && !vs_new;
    hs = hs_new;
    vs = vs_new;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (gx == line_len - 1) begin
      gx = 0;
      line_len = H_TOT;
      if (gy == frame_len - 1) gy = 0;
      else gy++;
    end else begin
      gx++;
    end
    driveSync();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  task automatic applyStimulus(input int tx, input int ty);
    int budget = 5000;
    stepCycle();
    while (!(gx == tx && gy == ty) && budget > 0) begin
      stepCycle();
      budget--;
    end
    if (!(gx == tx && gy == ty)) timeoutFail("reach_position");
  endtask

  task automatic waitFall(input bit on_vs, input string name);
    int budget = 3000;
    stepCycle();
    while (!(on_vs ? vs_fell : hs_fell) && budget > 0) begin
      stepCycle();
      budget--;
    end
    if (!(on_vs ? vs_fell : hs_fell)) timeoutFail(name);
  endtask

  // locked must stay low through the first two vs falls and rise one clock after the third
  task automatic expectRelock(input string name);
    for (int i = 1; i <= 3; i++) begin
      waitFall(1'b1, {name, "_vs"});
      checkOutput({name, "_before"}, locked, 0);
      stepCycle();
      checkOutput({name, "_after"}, locked, (i == 3) ? 1 : 0);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_x"}, x, 0);
    checkOutput({name, "_y"}, y, 0);
    checkOutput({name, "_de"}, de, 0);
    checkOutput({name, "_locked"}, locked, 0);
    checkOutput({name, "_h_total"}, h_total, 0);
    checkOutput({name, "_v_total"}, v_total, 0);
    checkOutput({name, "_err"}, err, 0);
  endtask

  initial begin
    int e0, d0;
    vecs[0] = '{0, 27, 0, 27, 0};
    vecs[1] = '{0, 0, 0, 0, 1};
    vecs[2] = '{63, 0, 63, 0, 1};
    vecs[3] = '{64, 0, 64, 0, 0};
    vecs[4] = '{79, 5, 79, 5, 0};
    vecs[5] = '{68, 12, 68, 12, 0};
    vecs[6] = '{0, 23, 0, 23, 1};
    vecs[7] = '{63, 23, 63, 23, 1};
    vecs[8] = '{0, 24, 0, 24, 0};
    vecs[9] = '{40, 29, 40, 29, 0};

    driveSync();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    checkAllZero("reset");
    rst = 1'b0;

    expectRelock("initial_lock");
    checkOutput("h_total_clean", h_total, 80);
    checkOutput("v_total_clean", v_total, 30);
    e0 = err_hi;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].gx, vecs[i].gy);
      checkOutput($sformatf("vec%0d_x", i), x, vecs[i].ex);
      checkOutput($sformatf("vec%0d_y", i), y, vecs[i].ey);
      checkOutput($sformatf("vec%0d_de", i), de, vecs[i].ede);
    end

    waitFall(1'b0, "hs_fall");
    checkOutput("x_at_hs_fall", x, 68);

    waitFall(1'b1, "de_frame_start");
    d0 = de_hi;
    waitFall(1'b1, "de_frame_end");
    checkOutput("de_per_frame", de_hi - d0, 1536);
    checkOutput("no_err_clean", err_hi - e0, 0);

    // one 81-clock line while locked
    applyStimulus(0, 10);
    line_len = 81;
    e0 = err_hi;
    applyStimulus(0, 13);
    checkOutput("stretch_err_cycles", err_hi - e0, 1);
    checkOutput("stretch_locked", locked, 0);
    expectRelock("relock_stretch");

    // frame shortened to 29 lines, and it stays that way
    applyStimulus(0, 27);
    frame_len = 29;
    e0 = err_hi;
    waitFall(1'b1, "short_vs");
    stepCycle();
    checkOutput("short_err", err, 1);
    checkOutput("short_locked", locked, 0);
    checkOutput("short_v_total", v_total, 29);
    stepCycle();
    checkOutput("short_err_one_cycle", err, 0);
    expectRelock("relock_short");
    checkOutput("short_v_total_relocked", v_total, 29);
    checkOutput("short_err_cycles", err_hi - e0, 1);

    // hs stuck high long enough to saturate the line counter
    applyStimulus(0, 0);
    e0 = err_hi;
    hs_hold = 1'b1;
    repeat (1100) stepCycle();
    hs_hold = 1'b0;
    checkOutput("hold_locked", locked, 0);
    repeat (50) stepCycle();
    checkOutput("hold_err_cycles", err_hi - e0, 1);
    expectRelock("relock_hold");

    // one-cycle reset in the middle of a locked frame
    applyStimulus(30, 10);
    rst = 1'b1;
    stepCycle();
    checkAllZero("midframe_reset");
    rst = 1'b0;
    expectRelock("relock_reset");

    // hs and vs fall together on line 20
    applyStimulus(67, 20);
    e0 = err_hi;
    vs_force = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("simul_y", y, 26);
    checkOutput("simul_x", x, 69);
    checkOutput("simul_v_total", v_total, 24);
    checkOutput("simul_locked", locked, 0);
    repeat (5) stepCycle();
    vs_force = 1'b0;
    checkOutput("simul_err_cycles", err_hi - e0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
